// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
//   Shared definitions for the EX-stage multiply/divide sequencer:
//   FSM state encoding, op_sel bit positions, handshake level names and
//   a one-hot helper.
//   Optional feature macro: DIV_ZERO_FAST_EN (used by muldiv_ctrl).
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } md_state_e;

    // op_sel is one-hot {mult, multu, div, divu, mthi, mtlo}
    localparam int OP_MULT  = 5;
    localparam int OP_MULTU = 4;
    localparam int OP_DIV   = 3;
    localparam int OP_DIVU  = 2;
    localparam int OP_MTHI  = 1;
    localparam int OP_MTLO  = 0;

    localparam logic Stop              = 1'b1;
    localparam logic NoStop            = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // LO value written by the divide-by-zero shortcut
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_lat_cnt.sv
// muldiv_ctrl_lat_cnt
//   Down-counter that times the fixed-latency multiplier.
//   Ports:
//     clk, resetn     clock, asynchronous active-low reset
//     load, load_val  load the start count (takes priority over dec)
//     dec             decrement by one; saturates at zero
//     zero            count has reached zero
module muldiv_ctrl_lat_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   EX-stage sequencer for the multiplier and the iterative divider. Accepts
//   one MULT/MULTU/DIV/DIVU/MTHI/MTLO per EX instruction, holds the operands
//   stable for the whole operation, requests an EX stall while a result is
//   pending and owns the architectural HI/LO registers.
//   Optional feature macro: DIV_ZERO_FAST_EN -- divide by zero bypasses the
//   divider and writes hi=src1, lo=32'hFFFF_FFFF without stalling.
//
//   Handshake: div_start rises in the first DIV_WAIT cycle and stays high
//   until the cycle in which div_ready is seen; in that cycle div_start is
//   low, the result is captured and stallreq drops. div_annul pulses for one
//   cycle when flush hits an in-flight divide.
//
//   Ports:
//     clk, resetn                clock, asynchronous active-low reset
//     op_valid, op_sel           EX instruction valid, one-hot op select
//     src1, src2                 rs / rt operands
//     ex_hold                    EX will not advance at the next edge
//     flush                      squash the in-flight EX op
//     mul_signed, mul_op1/2      multiplier operands (latched)
//     mul_result                 multiplier product
//     div_start, div_signed,
//     div_op1/2, div_annul       divider request side
//     div_ready, div_result      divider response {remainder, quotient}
//     stallreq                   EX stall request
//     hi, lo                     architectural HI/LO
//     dbg_state                  current FSM state
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 2,   // legal range 1..15
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [5:0]  op_sel,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        mul_signed,
    output logic [31:0] mul_op1,
    output logic [31:0] mul_op2,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output md_state_e   dbg_state
);

    md_state_e   state, state_nxt;
    logic [31:0] hi_q, lo_q, hi_nxt, lo_nxt;
    logic        hi_we, lo_we;
    logic [31:0] op1_q, op2_q;
    logic        sign_q;
    logic        op_load, cnt_load, cnt_dec, cnt_zero;
    logic        op_ok, is_mul, op_sign, div_fast;

    assign op_ok   = op_valid && is_onehot6(op_sel);
    assign is_mul  = op_sel[OP_MULT] | op_sel[OP_MULTU];
    assign op_sign = op_sel[OP_MULT] | op_sel[OP_DIV];

`ifdef DIV_ZERO_FAST_EN
    assign div_fast = (op_sel[OP_DIV] | op_sel[OP_DIVU]) && (src2 == 32'd0);
`else
    assign div_fast = 1'b0;
`endif

    muldiv_ctrl_lat_cnt #(.CNT_W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (CNT_W'(MUL_LATENCY - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q   <= '0;
            lo_q   <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            if (hi_we) hi_q <= hi_nxt;
            if (lo_we) lo_q <= lo_nxt;
            if (op_load) begin
                op1_q  <= src1;
                op2_q  <= src2;
                sign_q <= op_sign;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        stallreq  = NoStop;
        div_start = DivStop;
        div_annul = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        op_load   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        unique case (state)
            IDLE: begin
                if (op_ok) begin
                    if (op_sel[OP_MTHI]) begin
                        hi_we  = 1'b1;
                        hi_nxt = src1;
                    end else if (op_sel[OP_MTLO]) begin
                        lo_we  = 1'b1;
                        lo_nxt = src1;
                    end else if (is_mul) begin
                        op_load   = 1'b1;
                        cnt_load  = 1'b1;
                        stallreq  = Stop;
                        state_nxt = MUL_WAIT;
                    end else if (div_fast) begin
                        hi_we     = 1'b1;
                        hi_nxt    = src1;
                        lo_we     = 1'b1;
                        lo_nxt    = DIV_ZERO_LO;
                        state_nxt = ex_hold ? DONE : IDLE;
                    end else begin
                        op_load   = 1'b1;
                        stallreq  = Stop;
                        state_nxt = DIV_WAIT;
                    end
                end
            end
            MUL_WAIT: begin
                if (!cnt_zero) begin
                    stallreq = Stop;
                    cnt_dec  = 1'b1;
                end else begin
                    hi_we     = 1'b1;
                    lo_we     = 1'b1;
                    hi_nxt    = mul_result[63:32];
                    lo_nxt    = mul_result[31:0];
                    state_nxt = ex_hold ? DONE : IDLE;
                end
            end
            DIV_WAIT: begin
                case (div_ready)
                    DivResultReady: begin
                        hi_we     = 1'b1;
                        lo_we     = 1'b1;
                        hi_nxt    = div_result[63:32];
                        lo_nxt    = div_result[31:0];
                        state_nxt = ex_hold ? DONE : IDLE;
                    end
                    DivResultNotReady: begin
                        stallreq  = Stop;
                        div_start = DivStart;
                    end
                    default: ;
                endcase
            end
            DONE: begin
                // The completed instruction is still sitting in EX; wait
                // for it to leave rather than re-executing it.
                if (!ex_hold) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Flush squashes whatever is in flight, including a result that
        // would otherwise land on this edge.
        if (flush) begin
            state_nxt = IDLE;
            stallreq  = NoStop;
            div_start = DivStop;
            hi_we     = 1'b0;
            lo_we     = 1'b0;
            op_load   = 1'b0;
            cnt_load  = 1'b0;
            cnt_dec   = 1'b0;
            div_annul = (state == DIV_WAIT);
        end
    end

    assign mul_signed = sign_q;
    assign mul_op1    = op1_q;
    assign mul_op2    = op2_q;
    assign div_signed = sign_q;
    assign div_op1    = op1_q;
    assign div_op2    = op2_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;
  localparam logic [5:0] S_MULT  = 6'b100000;
  localparam logic [5:0] S_MULTU = 6'b010000;
  localparam logic [5:0] S_DIV   = 6'b001000;
  localparam logic [5:0] S_DIVU  = 6'b000100;
  localparam logic [5:0] S_MTHI  = 6'b000010;
  localparam logic [5:0] S_MTLO  = 6'b000001;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic op_valid = 1'b0, ex_hold = 1'b0, flush = 1'b0;
  logic [5:0] op_sel = '0;
  logic [31:0] src1 = '0, src2 = '0;
  logic mul_signed, div_start, div_signed, div_annul, div_ready, stallreq;
  logic [31:0] mul_op1, mul_op2, div_op1, div_op2, hi, lo;
  logic [63:0] mul_result, div_result;
  md_state_e dbg_state;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LATENCY(MUL_LAT), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_sel(op_sel),
    .src1(src1), .src2(src2), .ex_hold(ex_hold), .flush(flush),
    .mul_signed(mul_signed), .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_op1(div_op1), .div_op2(div_op2),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .stallreq(stallreq), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- arithmetic reference ----------------
  function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint p;
    if (sgn) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // ---------------- multiplier / divider environment ----------------
  int   div_lat = 1;
  int   div_cnt;
  logic div_busy;

  assign mul_result = mul_ref(mul_signed, mul_op1, mul_op2);
  assign div_result = div_ref(div_signed, div_op1, div_op2);
  assign div_ready  = div_busy && (div_cnt == div_lat);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_busy <= 1'b0;
      div_cnt  <= 0;
    end else if (div_annul || div_ready) begin
      div_busy <= 1'b0;
      div_cnt  <= 0;
    end else if (div_start) begin
      div_busy <= 1'b1;
      div_cnt  <= div_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      S_MULT:  {hi_m, lo_m} = mul_ref(1'b1, a, b);
      S_MULTU: {hi_m, lo_m} = mul_ref(1'b0, a, b);
      S_DIV:   {hi_m, lo_m} = div_ref(1'b1, a, b);
      S_DIVU:  {hi_m, lo_m} = div_ref(1'b0, a, b);
      S_MTHI:  hi_m = a;
      S_MTLO:  lo_m = a;
      default: ;
    endcase
  endtask

  function automatic int exp_stall(input logic [5:0] sel, input logic [31:0] b, input int lat);
    if (sel == S_MULT || sel == S_MULTU) return MUL_LAT;
    if (sel == S_DIV || sel == S_DIVU) begin
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) return 0;
`endif
      return lat + 1;
    end
    return 0;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input string tag, input logic [5:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input int hold);
    int stalls, want;
    bit done, is_mul, is_div, sgn;
    is_mul = (sel == S_MULT) || (sel == S_MULTU);
    is_div = (sel == S_DIV) || (sel == S_DIVU);
    sgn    = (sel == S_MULT) || (sel == S_DIV);
    if (!(is_mul || is_div)) hold = 0;
    want    = exp_stall(sel, b, lat);
    div_lat = lat;
    @(posedge clk); #1;
    op_valid = 1'b1; op_sel = sel; src1 = a; src2 = b; ex_hold = (hold > 0);
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (i > 0 && is_mul) begin
        check({tag, ":mul_signed"}, 64'(mul_signed), 64'(sgn));
        check({tag, ":mul_op1"}, 64'(mul_op1), 64'(a));
        check({tag, ":mul_op2"}, 64'(mul_op2), 64'(b));
      end
      if (i > 0 && is_div && want > 0) begin
        check({tag, ":div_signed"}, 64'(div_signed), 64'(sgn));
        check({tag, ":div_op1"}, 64'(div_op1), 64'(a));
        check({tag, ":div_op2"}, 64'(div_op2), 64'(b));
      end
      check({tag, ":div_start"}, 64'(div_start), 64'(is_div && i > 0 && i < want));
      if (!stallreq) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    check({tag, ":stall_cycles"}, 64'(stalls), 64'(want));
    model_op(sel, a, b);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      ex_hold = (h < hold - 1);
      @(negedge clk);
      check({tag, ":done_state"}, 64'(dbg_state), 64'(DONE));
      check({tag, ":done_stall"}, 64'(stallreq), 64'd0);
      check({tag, ":done_hi"}, 64'(hi), 64'(hi_m));
      check({tag, ":done_lo"}, 64'(lo), 64'(lo_m));
    end
    @(posedge clk); #1;
    op_valid = 1'b0; ex_hold = 1'b0; op_sel = '0;
    @(negedge clk);
    check({tag, ":idle_state"}, 64'(dbg_state), 64'(IDLE));
    check({tag, ":idle_stall"}, 64'(stallreq), 64'd0);
    check({tag, ":hi"}, 64'(hi), 64'(hi_m));
    check({tag, ":lo"}, 64'(lo), 64'(lo_m));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0]  sel;
    logic [31:0] a, b;

    // reset values
    #12;
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall", 64'(stallreq), 64'd0);
    check("rst_div_start", 64'(div_start), 64'd0);
    check("rst_div_annul", 64'(div_annul), 64'd0);
    check("rst_signed", 64'({mul_signed, div_signed}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("mthi", S_MTHI, 32'h1234_5678, 32'd0, 1, 0);
    run_op("mtlo", S_MTLO, 32'h9ABC_DEF0, 32'd0, 1, 0);
    run_op("mult_neg", S_MULT, 32'hFFFF_FFFD, 32'd7, 1, 0);
    check("mult_neg_value", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("divu_100_7", S_DIVU, 32'd100, 32'd7, 33, 0);
    check("divu_value", {32'(hi), 32'(lo)}, {32'd2, 32'd14});
    run_op("div_hold", S_DIV, 32'hFFFF_FF9C, 32'd7, 4, 3);
    run_op("multu_hold", S_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 2);
    run_op("div_zero", S_DIV, 32'hCAFE_0001, 32'd0, 3, 0);
    check("div_zero_value", {32'(hi), 32'(lo)}, {32'hCAFE_0001, 32'hFFFF_FFFF});
    run_op("sel_none", 6'b000000, 32'h1111_1111, 32'd2, 1, 0);
    run_op("sel_multi", 6'b100010, 32'h2222_2222, 32'd3, 1, 0);

    // flush in DIV_WAIT cycle 10
    div_lat = 40;
    @(posedge clk); #1;
    op_valid = 1'b1; op_sel = S_DIV; src1 = 32'd1000; src2 = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flush_div:annul", 64'(div_annul), 64'd1);
    check("flush_div:state", 64'(dbg_state), 64'(DIV_WAIT));
    check("flush_div:stall", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op_sel = '0;
    @(negedge clk);
    check("flush_div:annul_drop", 64'(div_annul), 64'd0);
    check("flush_div:idle", 64'(dbg_state), 64'(IDLE));
    check("flush_div:hi", 64'(hi), 64'(hi_m));
    check("flush_div:lo", 64'(lo), 64'(lo_m));
    check("flush_div:div_start", 64'(div_start), 64'd0);

    // flush in MUL_WAIT: no annul, no write
    @(posedge clk); #1;
    op_valid = 1'b1; op_sel = S_MULT; src1 = 32'd5; src2 = 32'd9;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_mul:annul", 64'(div_annul), 64'd0);
    check("flush_mul:stall", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op_sel = '0;
    @(negedge clk);
    check("flush_mul:idle", 64'(dbg_state), 64'(IDLE));
    check("flush_mul:hi", 64'(hi), 64'(hi_m));
    check("flush_mul:lo", 64'(lo), 64'(lo_m));

    // flush squashes an MTHI in IDLE
    @(posedge clk); #1;
    op_valid = 1'b1; op_sel = S_MTHI; src1 = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op_sel = '0;
    @(negedge clk);
    check("flush_mthi:hi", 64'(hi), 64'(hi_m));

    // randomized ops
    for (int n = 0; n < 24; n++) begin
      sel = 6'b000001 << $urandom_range(0, 5);
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (sel == S_DIV || sel == S_DIVU) begin
        if (b == 32'd0) b = 32'd1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      end
      run_op($sformatf("rnd%0d", n), sel, a, b, $urandom_range(1, 8), $urandom_range(0, 2));
    end

    // reset in the middle of a multiply
    run_op("pre_reset", S_MTLO, 32'h5555_AAAA, 32'd0, 1, 0);
    @(posedge clk); #1;
    op_valid = 1'b1; op_sel = S_MULT; src1 = 32'd123; src2 = 32'd456;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    check("midrst:state", 64'(dbg_state), 64'(IDLE));
    check("midrst:hi", 64'(hi), 64'(hi_m));
    check("midrst:lo", 64'(lo), 64'(lo_m));
    check("midrst:mul_op1", 64'(mul_op1), 64'd0);
    check("midrst:mul_signed", 64'(mul_signed), 64'd0);
    op_valid = 1'b0; op_sel = '0;
    @(negedge clk);
    resetn = 1'b1;
    run_op("post_reset", S_MULTU, 32'd3, 32'd4, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
